lsu_sequencer: RTL and testbench
================================

# lsu_sequencer

Multi-cycle load/store sequencer between the RV32I decode/execute stages and a word-wide data memory bus. It accepts one memory request at a time, described by the decoder's mem_read/mem_write, size and signedness outputs plus the ALU-computed address. It generates byte-lane-enabled bus beats, extracts and extends load data, and stalls the pipeline until the access completes.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present; qualified by req_ready.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned access rejected; valid with resp_valid.
- stall  out  1  pipeline hold.
- bus_req  out  1  bus beat request; held until bus_ack.
- bus_we  out  1  beat is a write.
- bus_addr  out  32  word-aligned beat address; bits [1:0] always 0.
- bus_be  out  4  byte-lane enables; bit n selects data[8n+7:8n].
- bus_wdata  out  32  lane-positioned write data.
- bus_ack  in  1  beat complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  read data.

## Operation
- The FSM has four states: IDLE, ACC0, ACC1, RESP.
- req_ready is 1 only in IDLE.
- Accept: when req_valid && req_ready, the sequencer latches all req_* fields and computes off = addr[1:0].
- Misaligned: a half with off = 3, or a word with off != 0.
- Lanes: byte uses be = 0001<<off. Half uses be = 0011<<off. Word uses be = 1111. For a split access, the shifted 8-bit lane mask is used: beat 0 takes its low nibble, beat 1 takes its high nibble.
- Store data: bus_wdata = req_wdata << (8*off), taking the low 32 bits for beat 0. Beat 1 uses req_wdata >> (8*(4-off)).
- Transitions from IDLE on accept:
  - Aligned: go to ACC0.
  - Misaligned with LSU_MISALIGN_EN defined: go to ACC0 and mark the access split.
  - Misaligned without it: go to RESP with fault set, issuing no bus beat.
- ACC0: bus_addr = {addr[31:2],2'b00}. On bus_ack, go to ACC1 if split, else RESP.
- ACC1: bus_addr = beat-0 address + 4, modulo 2^32. On bus_ack, go to RESP.
- Load assembly: the bytes of each acked beat are captured into a 64-bit staging register. The result is the size-selected field starting at byte off, extended per req_signed and req_size.
- RESP: resp_valid = 1 for exactly one cycle, then the FSM returns to IDLE. No new request is accepted in RESP.
- stall = (IDLE && req_valid) || ACC0 || ACC1. stall is 0 in RESP, so the pipeline advances on the same edge that delivers the result.

## Timing
- Reset values: state IDLE, req_ready 1, and 0 on every other output including bus_addr, bus_be, bus_wdata, resp_rdata and the staging register.
- bus_req is registered from the state; it is never combinational from req_valid.
- Aligned access with zero-wait ack: accept at edge 0, ACC0 in cycle 1 with ack, resp_valid in cycle 2. Latency is 2 cycles.
- Split access: 3 cycles minimum. Each wait cycle (bus_req=1, bus_ack=0) adds one cycle.
- Bus outputs hold stable while bus_req=1 && !bus_ack.
- bus_ack while bus_req=0 is ignored.
- Fault path: accept, RESP next cycle with resp_fault=1. Latency is 1 cycle.
- Asynchronous reset mid-access: bus_req drops immediately and the FSM returns to IDLE. The beat in flight is abandoned and no resp_valid is produced.

## Configuration
- LSU_MISALIGN_EN defined: misaligned half/word accesses are split into two beats, and resp_fault is tied to 0.
- LSU_MISALIGN_EN undefined: ACC1 and the split logic are removed. Misaligned requests fault with no bus activity.

## Test plan
- Aligned signed load byte, addr 0x1002, bus_rdata 0x00800000, immediate ack:
  - Bus side: bus_addr 0x1000, bus_be 0100.
  - Response: resp_rdata 0xFFFFFF80 in cycle 2.
  - Repeat unsigned: expect 0x00000080.
- Store half, addr 0x2001, wdata 0x0000ABCD:
  - Expect bus_we 1, bus_be 0110, bus_wdata 0x00ABCD00.
  - Then resp_valid with resp_rdata 0.
- Load word, addr 0x3000, bus_ack delayed 3 cycles:
  - bus outputs stable and stall 1 throughout the wait.
  - resp_valid in cycle 5.
- Misaligned word load at 0xFFFFFFFE, with LSU_MISALIGN_EN:
  - Beats at 0xFFFFFFFC (be 1100) then 0x00000000 (be 0011).
  - bus_rdata 0x5566xxxx then 0xxxxx7788 yields resp_rdata 0x77885566.
- Same misaligned request without LSU_MISALIGN_EN:
  - No bus_req.
  - resp_valid and resp_fault both 1 in cycle 1, resp_rdata 0.
- Reset asserted in ACC0 during a wait state:
  - bus_req 0 the same cycle, then req_ready 1.
  - No resp_valid follows.
  - The next aligned request completes normally.

Source files
------------

// File: rtl/lsu_sequencer.sv
// RV32I load/store sequencer: one request at a time, word-wide bus beats with byte lanes,
// load extraction/extension and pipeline stall. Define LSU_MISALIGN_EN to split misaligned accesses.
module lsu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready; a bus beat
  // completes on a rising edge with bus_req && bus_ack, and its outputs hold until then.
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_nx;
  logic [1:0]  off;
  logic        accept;
  logic        misaligned;
  logic        beat_ok;
  logic [3:0]  lane_lo;
  logic [31:0] wdata_lo;

  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [63:0] staging_q;
  logic [31:0] field;
  logic [31:0] load_ext;

  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;

`ifdef LSU_MISALIGN_EN
  logic [7:0]  base8;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic [3:0]  lane_hi;
  logic [31:0] wdata_hi;
  logic        split_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wdata_hi_q;
`else
  logic [3:0]  base4;
  logic        fault_q;
`endif

  // Request decode: lane mask and lane-positioned store data for the beat(s).
  always_comb begin
    off     = req_addr[1:0];
    accept  = req_valid && (state == IDLE);
    case (req_size)
      2'b10:   misaligned = 1'b0;
      2'b01:   misaligned = (off == 2'b11);
      default: misaligned = (off != 2'b00);
    endcase
`ifdef LSU_MISALIGN_EN
    beat_ok = 1'b1;
    case (req_size)
      2'b10:   base8 = 8'h01;
      2'b01:   base8 = 8'h03;
      default: base8 = 8'h0F;
    endcase
    mask8    = base8 << off;
    lane_lo  = mask8[3:0];
    lane_hi  = mask8[7:4];
    wdata64  = {32'd0, req_wdata} << {off, 3'b000};
    wdata_lo = wdata64[31:0];
    wdata_hi = wdata64[63:32];
`else
    beat_ok = !misaligned;
    case (req_size)
      2'b10:   base4 = 4'h1;
      2'b01:   base4 = 4'h3;
      default: base4 = 4'hF;
    endcase
    lane_lo  = base4 << off;
    wdata_lo = req_wdata << {off, 3'b000};
`endif
  end

  // Load extraction from the staging register, starting at byte off.
  always_comb begin
    field = 32'(staging_q >> {off_q, 3'b000});
    case (size_q)
      2'b10:   load_ext = signed_q ? {{24{field[7]}}, field[7:0]} : {24'd0, field[7:0]};
      2'b01:   load_ext = signed_q ? {{16{field[15]}}, field[15:0]} : {16'd0, field[15:0]};
      default: load_ext = field;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_EN
          state_nx = ACC0;
`else
          state_nx = misaligned ? RESP : ACC0;
`endif
        end
      end
      ACC0: begin
        if (bus_ack) begin
`ifdef LSU_MISALIGN_EN
          state_nx = split_q ? ACC1 : RESP;
`else
          state_nx = RESP;
`endif
        end
      end
      ACC1: begin
`ifdef LSU_MISALIGN_EN
        if (bus_ack) state_nx = RESP;
`else
        state_nx = IDLE;
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      staging_q   <= 64'd0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
`ifdef LSU_MISALIGN_EN
      split_q     <= 1'b0;
      be_hi_q     <= 4'd0;
      wdata_hi_q  <= 32'd0;
`else
      fault_q     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        size_q   <= req_size;
        off_q    <= off;
`ifdef LSU_MISALIGN_EN
        split_q    <= misaligned;
        be_hi_q    <= lane_hi;
        wdata_hi_q <= req_write ? wdata_hi : 32'd0;
`else
        fault_q    <= misaligned;
`endif
        if (beat_ok) begin
          bus_we_q    <= req_write;
          bus_addr_q  <= {req_addr[31:2], 2'b00};
          bus_be_q    <= lane_lo;
          bus_wdata_q <= req_write ? wdata_lo : 32'd0;
        end
      end
      if (state == ACC0 && bus_ack) begin
        staging_q[31:0] <= bus_rdata;
`ifdef LSU_MISALIGN_EN
        if (split_q) begin
          bus_addr_q  <= bus_addr_q + 32'd4;
          bus_be_q    <= be_hi_q;
          bus_wdata_q <= wdata_hi_q;
        end
`endif
      end
`ifdef LSU_MISALIGN_EN
      if (state == ACC1 && bus_ack) staging_q[63:32] <= bus_rdata;
`endif
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    stall      = ((state == IDLE) && req_valid) || (state == ACC0) || (state == ACC1);
    bus_req    = (state == ACC0) || (state == ACC1);
    resp_valid = (state == RESP);
`ifdef LSU_MISALIGN_EN
    resp_fault = 1'b0;
    resp_rdata = (state == RESP && !write_q) ? load_ext : 32'd0;
`else
    resp_fault = (state == RESP) && fault_q;
    resp_rdata = (state == RESP && !write_q && !fault_q) ? load_ext : 32'd0;
`endif
  end

  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: aligned loads/stores, wait states, misaligned handling, reset mid-access.
module tb_lsu_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in the current IDLE cycle and returns just after the accepting edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    #1;
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    chk("accept_stall", {31'd0, stall}, 32'd1);
    cyc();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
  endtask

  // Single beat with immediate ack, then checks the response cycle and the return to IDLE.
  task automatic beat_then_resp(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic exp_we, input logic [31:0] exp_wdata,
                                input logic [31:0] rdata, input logic [31:0] exp_rdata);
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd1);
    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
    chk({tag, "_bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
    chk({tag, "_bus_we"}, {31'd0, bus_we}, {31'd0, exp_we});
    if (exp_we) chk({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
    chk({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    cyc();
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_resp_fault"}, {31'd0, resp_fault}, 32'd0);
    chk({tag, "_resp_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_resp_busreq"}, {31'd0, bus_req}, 32'd0);
    cyc();
    chk({tag, "_after_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_after_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;

    // reset state
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    cyc(); cyc();
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // signed / unsigned byte loads at off 2
    issue(1'b0, 2'b10, 1'b1, 32'h0000_1002, 32'd0);
    beat_then_resp("lb", 32'h0000_1000, 4'b0100, 1'b0, 32'd0, 32'h0080_0000, 32'hFFFF_FF80);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'd0);
    beat_then_resp("lbu", 32'h0000_1000, 4'b0100, 1'b0, 32'd0, 32'h0080_0000, 32'h0000_0080);

    // store half at off 1
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2001, 32'h0000_ABCD);
    beat_then_resp("sh", 32'h0000_2000, 4'b0110, 1'b1, 32'h00AB_CD00, 32'hDEAD_BEEF, 32'd0);

    // signed half load at off 2, byte store at off 3, size 11 treated as word
    issue(1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'd0);
    beat_then_resp("lh", 32'h0000_4000, 4'b1100, 1'b0, 32'd0, 32'h8001_1234, 32'hFFFF_8001);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_4443, 32'h1234_56A5);
    beat_then_resp("sb", 32'h0000_4440, 4'b1000, 1'b1, 32'hA500_0000, 32'h0, 32'd0);
    issue(1'b0, 2'b11, 1'b1, 32'h0000_5000, 32'd0);
    beat_then_resp("lw11", 32'h0000_5000, 4'b1111, 1'b0, 32'd0, 32'h8765_4321, 32'h8765_4321);

    // word load with three wait cycles: response in cycle 5
    issue(1'b0, 2'b00, 1'b0, 32'h0000_3000, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("wait_bus_req", {31'd0, bus_req}, 32'd1);
      chk("wait_bus_addr", bus_addr, 32'h0000_3000);
      chk("wait_bus_be", {28'd0, bus_be}, 32'h0000_000F);
      chk("wait_bus_we", {31'd0, bus_we}, 32'd0);
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_resp_valid", {31'd0, resp_valid}, 32'd0);
      cyc();
    end
    beat_then_resp("lw_wait", 32'h0000_3000, 4'b1111, 1'b0, 32'd0, 32'h1234_5678, 32'h1234_5678);

    // bus_ack while idle is ignored
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    cyc();
    bus_ack = 1'b0;
    chk("stray_ack_valid", {31'd0, resp_valid}, 32'd0);
    chk("stray_ack_ready", {31'd0, req_ready}, 32'd1);
    chk("stray_ack_busreq", {31'd0, bus_req}, 32'd0);

`ifdef LSU_MISALIGN_EN
    // split word load across the address wrap
    issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'd0);
    chk("split_b0_req", {31'd0, bus_req}, 32'd1);
    chk("split_b0_addr", bus_addr, 32'hFFFF_FFFC);
    chk("split_b0_be", {28'd0, bus_be}, 32'h0000_000C);
    bus_ack = 1'b1;
    bus_rdata = 32'h5566_AAAA;
    cyc();
    chk("split_b1_req", {31'd0, bus_req}, 32'd1);
    chk("split_b1_addr", bus_addr, 32'h0000_0000);
    chk("split_b1_be", {28'd0, bus_be}, 32'h0000_0003);
    chk("split_b1_stall", {31'd0, stall}, 32'd1);
    chk("split_b1_valid", {31'd0, resp_valid}, 32'd0);
    bus_rdata = 32'hBBBB_7788;
    cyc();
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    chk("split_valid", {31'd0, resp_valid}, 32'd1);
    chk("split_rdata", resp_rdata, 32'h7788_5566);
    chk("split_fault", {31'd0, resp_fault}, 32'd0);
    cyc();
    chk("split_done_ready", {31'd0, req_ready}, 32'd1);

    // split half store at off 3
    issue(1'b1, 2'b01, 1'b0, 32'h0000_6003, 32'h0000_BEEF);
    chk("ssplit_b0_be", {28'd0, bus_be}, 32'h0000_0008);
    chk("ssplit_b0_wdata", bus_wdata, 32'hEF00_0000);
    bus_ack = 1'b1;
    cyc();
    chk("ssplit_b1_addr", bus_addr, 32'h0000_6004);
    chk("ssplit_b1_be", {28'd0, bus_be}, 32'h0000_0001);
    chk("ssplit_b1_wdata", bus_wdata, 32'h0000_00BE);
    cyc();
    bus_ack = 1'b0;
    chk("ssplit_valid", {31'd0, resp_valid}, 32'd1);
    chk("ssplit_rdata", resp_rdata, 32'd0);
    cyc();
`else
    // misaligned word and half fault without bus activity
    issue(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'd0);
    chk("fault_w_busreq", {31'd0, bus_req}, 32'd0);
    chk("fault_w_valid", {31'd0, resp_valid}, 32'd1);
    chk("fault_w_fault", {31'd0, resp_fault}, 32'd1);
    chk("fault_w_rdata", resp_rdata, 32'd0);
    chk("fault_w_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("fault_w_after_valid", {31'd0, resp_valid}, 32'd0);
    chk("fault_w_after_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_6003, 32'h0000_BEEF);
    chk("fault_h_busreq", {31'd0, bus_req}, 32'd0);
    chk("fault_h_valid", {31'd0, resp_valid}, 32'd1);
    chk("fault_h_fault", {31'd0, resp_fault}, 32'd1);
    cyc();
    chk("fault_h_after_fault", {31'd0, resp_fault}, 32'd0);
`endif

    // reset during an ACC0 wait state
    issue(1'b0, 2'b00, 1'b0, 32'h0000_7000, 32'd0);
    chk("rstmid_busreq_pre", {31'd0, bus_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_busreq_now", {31'd0, bus_req}, 32'd0);
    chk("rstmid_ready_now", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_valid", {31'd0, resp_valid}, 32'd0);
      chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
      cyc();
    end
    issue(1'b0, 2'b00, 1'b0, 32'h0000_8004, 32'd0);
    beat_then_resp("post_rst_lw", 32'h0000_8004, 4'b1111, 1'b0, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
